otsu_class_stats: RTL
=====================

// Module: otsu_class_stats
// PURPOSE
//  Streaming fixed-point successor to the single-bin class-probability block of the Otsu path.
//  Consumes one histogram frame as (bin, count) beats and accumulates class-0 (bin < thresh) count,
//  class-0 first moment and frame total. On the last beat it divides class-0 count by total.
//  It then presents w0 and w1 = 1 - w0 in unsigned Q1.FRAC_W to the between-class variance stage.
// PARAMETERS
//  BIN_W    8   histogram bin index width; a frame holds at most 2**BIN_W beats
//  CNT_W    32  per-bin count width
//  FRAC_W   16  fractional bits of w0/w1
// PORTS
//  clk          in   1             rising-edge clock
//  reset        in   1             synchronous, active-high reset
//  thresh       in   BIN_W         candidate threshold, sampled on the first accepted beat of a frame
//  in_valid     in   1             beat valid
//  in_ready     out  1             beat accepted when in_valid && in_ready
//  in_bin       in   BIN_W         bin index i
//  in_count     in   CNT_W         n_i
//  in_last      in   1             final beat of frame
//  out_valid    out  1             result valid, held until out_ready
//  out_ready    in   1             downstream accept
//  w0           out  FRAC_W+1      class-0 probability, Q1.FRAC_W
//  w1           out  FRAC_W+1      class-1 probability, Q1.FRAC_W
//  sum0         out  CNT_W+BIN_W   sum of n_i for i < thresh
//  mom0         out  CNT_W+2*BIN_W sum of i*n_i for i < thresh
//  total        out  CNT_W+BIN_W   sum of all n_i in frame
//  div0         out  1             total was zero
//  sat          out  1             an accumulator saturated (frame longer than 2**BIN_W beats)
// BEHAVIOUR
//  Reset: every output is 0 except in_ready = 1. Accumulators and the latched threshold clear; state = ACCUM.
//  States: ACCUM -> (accepted in_last) -> DIVIDE, or directly RESULT if total == 0 -> (out_valid && out_ready) -> ACCUM.
//  ACCUM: in_ready = 1. Each accepted beat does total += n. If in_bin < thr it also does sum0 += n and mom0 += in_bin*n.
//  n = 0 is legal and changes nothing. thr is latched on the frame's first beat and ignores later thresh changes.
//  The in_last beat is itself accumulated before the state leaves ACCUM.
//  A one-beat frame with in_last is legal.
//  Accumulators saturate at all-ones instead of wrapping. sat is sticky per frame.
//  DIVIDE: in_ready = 0. The divider computes q = floor((sum0 << FRAC_W) / total) with a restoring divider.
//  The divider resolves one quotient bit per cycle, FRAC_W+1 iterations. q <= 1<<FRAC_W always.
//  RESULT: out_valid = 1. w0 = q and w1 = (1<<FRAC_W) - q.
//  sum0, mom0, total, div0 and sat are registered and stable while out_valid is 1.
//  When total == 0, div0 = 1 and w0 = w1 = 0. The divider is skipped, giving RESULT one cycle after the in_last acceptance.
//  Latency, total != 0: out_valid rises FRAC_W+3 cycles after the in_last acceptance edge (start + FRAC_W+1 iterations + load).
//  The same edge that retires a result (out_valid && out_ready) clears the accumulators, sat and out_valid.
//  in_ready rises on that edge, so a new frame may be accepted in the following cycle.
//  Backpressure: in_ready stays 0 for the whole of DIVIDE and RESULT, with no input buffering.
//  in_valid during these states is ignored and not dropped silently, since it is never accepted.
//  reset has priority over every event and aborts a frame or division mid-operation. It produces no partial out_valid.
//  thr = 0 gives an empty class 0 (w0 = 0). thr = all-ones excludes only the top bin.
// STRUCTURE
//  Package otsu_pkg: state encoding (ACCUM, DIVIDE, RESULT) and the width functions SUM_W = CNT_W+BIN_W and MOM_W = CNT_W+2*BIN_W.
//  Sub-module otsu_frac_divider: parametrised restoring divider (DVD_W, DVS_W, Q_W) with start/busy/done and a divide-by-zero flag.
//  The top level holds the saturating accumulators, the threshold latch, the FSM and the output registers.
// TESTING (FRAC_W=16, BIN_W=8)
//  1 thr=128, bins 0..255 each n=1 -> total=256, sum0=128, mom0=8128, w0=0x08000, w1=0x08000, div0=0.
//  2 thr=0, same frame -> sum0=0, mom0=0, w0=0, w1=0x10000.
//  3 beats bin3 n=1, bin200 n=2 (last), thr=100 -> total=3, sum0=1, mom0=3, w0=21845, w1=43691.
//    out_valid rises exactly 19 cycles after the last accepted beat.
//  4 all n=0 -> div0=1, w0=w1=0, out_valid 1 cycle after in_last.
//    Then a frame of 257 beats of n=0xFFFFFFFF -> sat=1 and total saturated.
//  5 out_ready held low 10 cycles -> outputs stable and in_ready=0 throughout.
//    On release, the next frame's first beat is accepted in the next cycle.
//    thresh changed mid-frame -> no effect on the result.
//  6 reset pulsed during DIVIDE -> next cycle all outputs 0, in_ready=1.
//    A following frame (as in test 1) gives the test 1 result.

Source files
------------

// File: rtl/otsu_pkg.sv
// Shared state encoding and accumulator width helpers for the Otsu class-statistics path.
package otsu_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        RESULT = 2'd2
    } otsu_state_e;

    function automatic int sum_w(input int cnt_w, input int bin_w);
        return cnt_w + bin_w;
    endfunction

    function automatic int mom_w(input int cnt_w, input int bin_w);
        return cnt_w + 2 * bin_w;
    endfunction

endpackage

// File: rtl/otsu_frac_divider.sv
// Restoring divider resolving one quotient bit per cycle over Q_W iterations.
// The caller guarantees the quotient fits in Q_W bits (dividend < divisor << Q_W).
module otsu_frac_divider #(
    parameter int DVD_W = 56,
    parameter int DVS_W = 40,
    parameter int Q_W   = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [Q_W-1:0]   quotient
);
    localparam int REM_W = DVS_W + 1;
    localparam int CNT_B = $clog2(Q_W + 1);

    logic [REM_W-1:0] rem_q, rem_d, trial;
    logic [Q_W-1:0]   dvd_q, dvd_d, quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_B-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, qbit;

    always_comb begin
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        qbit   = 1'b0;
        trial  = {rem_q[REM_W-2:0], dvd_q[Q_W-1]};
        if (start) begin
            // Upper dividend bits are already below the divisor, so only Q_W steps remain.
            dvs_d  = divisor;
            dvd_d  = dividend[Q_W-1:0];
            rem_d  = REM_W'(dividend >> Q_W);
            quo_d  = '0;
            cnt_d  = CNT_B'(Q_W);
            dbz_d  = (divisor == '0);
            busy_d = (divisor != '0);
            done_d = (divisor == '0);
        end else if (busy_q) begin
            qbit   = (trial >= {1'b0, dvs_q});
            rem_d  = qbit ? (trial - {1'b0, dvs_q}) : trial;
            quo_d  = {quo_q[Q_W-2:0], qbit};
            dvd_d  = dvd_q << 1;
            cnt_d  = cnt_q - CNT_B'(1);
            if (cnt_q == CNT_B'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dbz      = dbz_q;
    assign quotient = quo_q;

endmodule

// File: rtl/otsu_class_stats.sv
// Streaming class-0 statistics for one histogram frame, ending in w0 = sum0/total and w1 = 1 - w0.
module otsu_class_stats
    import otsu_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int CNT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BIN_W-1:0]         thresh,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BIN_W-1:0]         in_bin,
    input  logic [CNT_W-1:0]         in_count,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FRAC_W:0]          w0,
    output logic [FRAC_W:0]          w1,
    output logic [CNT_W+BIN_W-1:0]   sum0,
    output logic [CNT_W+2*BIN_W-1:0] mom0,
    output logic [CNT_W+BIN_W-1:0]   total,
    output logic                     div0,
    output logic                     sat
);
    localparam int SUM_W = sum_w(CNT_W, BIN_W);
    localparam int MOM_W = mom_w(CNT_W, BIN_W);
    localparam int SUM_X = SUM_W + 1;
    localparam int MOM_X = MOM_W + 1;
    localparam int Q_W   = FRAC_W + 1;
    localparam logic [FRAC_W:0] W_ONE = {1'b1, {FRAC_W{1'b0}}};

    otsu_state_e      state_q, state_d;
    logic [BIN_W-1:0] thr_q, thr_d, eff_thr;
    logic [SUM_W-1:0] sum0_q, sum0_d, total_q, total_d, tot_sat;
    logic [MOM_W-1:0] mom0_q, mom0_d;
    logic [SUM_W:0]   tot_x, sum_x;
    logic [MOM_W:0]   mom_x;
    logic [FRAC_W:0]  w0_q, w0_d, w1_q, w1_d;
    logic             first_q, first_d, sat_q, sat_d, in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d, div0_q, div0_d, div_start_q, div_start_d;
    logic             accept, in_cls0, div_busy, div_done, div_dbz;
    logic [Q_W-1:0]   div_q;

    otsu_frac_divider #(.DVD_W(SUM_W + FRAC_W), .DVS_W(SUM_W), .Q_W(Q_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_q),
        .dividend ({sum0_q, {FRAC_W{1'b0}}}),
        .divisor  (total_q),
        .busy     (div_busy),
        .done     (div_done),
        .dbz      (div_dbz),
        .quotient (div_q)
    );

    // One extra bit catches the carry that triggers saturation.
    assign accept  = in_valid && in_ready_q;
    assign eff_thr = first_q ? thresh : thr_q;
    assign in_cls0 = (in_bin < eff_thr);
    assign tot_x   = {1'b0, total_q} + SUM_X'(in_count);
    assign sum_x   = {1'b0, sum0_q} + SUM_X'(in_count);
    assign mom_x   = {1'b0, mom0_q} + MOM_X'(in_bin) * MOM_X'(in_count);
    assign tot_sat = tot_x[SUM_W] ? '1 : tot_x[SUM_W-1:0];

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        first_d     = first_q;
        sum0_d      = sum0_q;
        mom0_d      = mom0_q;
        total_d     = total_q;
        sat_d       = sat_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        div0_d      = div0_q;
        div_start_d = 1'b0;
        case (state_q)
            ACCUM: if (accept) begin
                thr_d   = eff_thr;
                first_d = 1'b0;
                total_d = tot_sat;
                sat_d   = sat_q | tot_x[SUM_W];
                if (in_cls0) begin
                    sum0_d = sum_x[SUM_W] ? '1 : sum_x[SUM_W-1:0];
                    mom0_d = mom_x[MOM_W] ? '1 : mom_x[MOM_W-1:0];
                    sat_d  = sat_q | tot_x[SUM_W] | sum_x[SUM_W] | mom_x[MOM_W];
                end
                if (in_last) begin
                    in_ready_d  = 1'b0;
                    state_d     = (tot_sat == '0) ? RESULT : DIVIDE;
                    div_start_d = (tot_sat != '0);
                end
            end
            DIVIDE: if (div_done && !div_busy) begin
                state_d     = RESULT;
                out_valid_d = 1'b1;
                w0_d        = div_q;
                w1_d        = W_ONE - div_q;
                div0_d      = div_dbz;
            end
            RESULT: begin
                // Arriving here without out_valid means the zero-total path skipped the divider.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    div0_d      = 1'b1;
                    w0_d        = '0;
                    w1_d        = '0;
                end else if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    first_d     = 1'b1;
                    sum0_d      = '0;
                    mom0_d      = '0;
                    total_d     = '0;
                    sat_d       = 1'b0;
                    w0_d        = '0;
                    w1_d        = '0;
                    div0_d      = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            thr_q       <= '0;
            first_q     <= 1'b1;
            sum0_q      <= '0;
            mom0_q      <= '0;
            total_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            w0_q        <= '0;
            w1_q        <= '0;
            div0_q      <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            first_q     <= first_d;
            sum0_q      <= sum0_d;
            mom0_q      <= mom0_d;
            total_q     <= total_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            div0_q      <= div0_d;
            div_start_q <= div_start_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign w0        = w0_q;
    assign w1        = w1_q;
    assign sum0      = sum0_q;
    assign mom0      = mom0_q;
    assign total     = total_q;
    assign div0      = div0_q;
    assign sat       = sat_q;

endmodule
